// File: rtl/if_sequencer.sv
// if_sequencer: instruction-fetch sequencer.
// The FSM (IDLE/FETCH/HALTED/FAULT) drives a word-aligned pc onto imem_addr
// and registers the returned word into a single-entry instruction register
// with a valid/ready handshake toward decode.
// Optional feature: define IF_BOUNDS_CHECK_EN to trap fetches at or beyond
// MEM_WORDS into the sticky FAULT state (cleared only by rst).
module if_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_WORDS = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        halt,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [1:0]  state,
   output logic        fault,
   output logic [15:0] fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_HALTED = 2'd2,
      S_FAULT  = 2'd3
   } state_t;

`ifdef IF_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);
   localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

   state_t      st;
   logic [31:0] pc;

   logic xfer;       // decode takes the held instruction this edge
   logic can_load;   // FETCH wants a new word and nothing overrides it
   logic oob;        // pc points past the end of instruction memory
   logic do_load;
   logic do_fault;
   logic do_redir;

   assign imem_addr = pc;
   assign state     = st;

`ifdef IF_BOUNDS_CHECK_EN
   assign fault = (st == S_FAULT);
`else
   assign fault = 1'b0;
`endif

   // Decode the per-cycle actions: transfer, load, redirect and range trap.
   always_comb begin
      xfer     = instr_valid & instr_ready;
      can_load = (st == S_FETCH) & ~halt & ~redirect_valid & (~instr_valid | instr_ready);
      oob      = BOUNDS_EN && ({2'b00, pc[31:2]} >= MEM_WORDS_W);
      do_load  = can_load & ~oob;
      do_fault = can_load & oob;
      do_redir = redirect_valid & ((st == S_FETCH) | (st == S_HALTED));
   end

   // FSM, pc, instruction register and transfer counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= S_IDLE;
         pc          <= RESET_PC & ALIGN_MASK;
         instr_valid <= 1'b0;
         instr       <= 32'd0;
         instr_pc    <= 32'd0;
         fetch_count <= 16'd0;
      end else begin
         // A transfer counts even on a flushing edge.
         if (xfer && fetch_count != 16'hFFFF)
            fetch_count <= fetch_count + 16'd1;

         case (st)
            S_IDLE:   if (run && !halt) st <= S_FETCH;
            S_FETCH:  if (halt) st <= S_HALTED;
                      else if (do_fault) st <= S_FAULT;
            S_HALTED: if (run && !halt) st <= S_FETCH;
            S_FAULT:  st <= S_FAULT;
            default:  st <= S_IDLE;
         endcase

         // Redirect wins over a sequential load; a trapped fetch holds pc.
         if (do_redir)
            pc <= redirect_pc & ALIGN_MASK;
         else if (do_load)
            pc <= pc + 32'd4;

         if (do_redir)
            instr_valid <= 1'b0;
         else if (do_load)
            instr_valid <= 1'b1;
         else if (xfer)
            instr_valid <= 1'b0;

         if (do_load) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
         end
      end
   end

endmodule

// File: tb/tb_if_sequencer.sv
// tb_if_sequencer: directed stimulus with a behavioural reference model that
// is compared against the DUT every cycle, plus hand-computed checkpoints.
module tb_if_sequencer;

   localparam int MW = 24;

   logic        clk = 1'b0;
   logic        rst, run, halt, redirect_valid, instr_ready;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, instr, instr_pc;
   logic        instr_valid, fault;
   logic [1:0]  state;
   logic [15:0] fetch_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   if_sequencer #(.RESET_PC(32'h0), .MEM_WORDS(MW)) dut (
      .clk(clk), .rst(rst), .run(run), .halt(halt),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc), .state(state),
      .fault(fault), .fetch_count(fetch_count)
   );

   // Instruction memory contents: word i holds A000_0000 + i.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return (addr[31:2] < 30'd64) ? (32'hA000_0000 + {2'b00, addr[31:2]}) : 32'hDEAD_BEEF;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

`ifdef IF_BOUNDS_CHECK_EN
   localparam bit BCHK = 1'b1;
`else
   localparam bit BCHK = 1'b0;
`endif

   // Reference model: "mode" names the sequencer's situation in plain terms.
   int          m_mode;   // 0 idle, 1 fetching, 2 halted, 3 faulted
   logic [31:0] m_pc, m_instr, m_ipc;
   bit          m_full;
   int          m_cnt;
   bit          m_live = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0; m_pc = 0; m_full = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
         m_live = 1;
      end else if (m_live) begin
         bit taken, wants, flush;
         int nxt;
         taken = m_full && instr_ready;
         if (taken && m_cnt < 65535) m_cnt++;
         flush = redirect_valid && (m_mode == 1 || m_mode == 2);
         wants = (m_mode == 1) && !halt && !redirect_valid && (!m_full || instr_ready);
         nxt = m_mode;
         if (m_mode == 0 && run && !halt) nxt = 1;
         if (m_mode == 2 && run && !halt) nxt = 1;
         if (m_mode == 1 && halt) nxt = 2;
         if (taken) m_full = 0;
         if (wants && BCHK && (m_pc / 4) >= MW) begin
            nxt = 3;
         end else if (wants) begin
            m_instr = mem_word(m_pc);
            m_ipc   = m_pc;
            m_full  = 1;
            m_pc    = m_pc + 4;
         end
         if (flush) begin
            m_pc   = {redirect_pc[31:2], 2'b00};
            m_full = 0;
         end
         m_mode = nxt;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (m_live && !rst) begin
         chk("m_state", {30'd0, state}, m_mode);
         chk("m_addr", imem_addr, m_pc);
         chk("m_valid", {31'd0, instr_valid}, {31'd0, m_full});
         if (m_full) begin
            chk("m_instr", instr, m_instr);
            chk("m_ipc", instr_pc, m_ipc);
         end
         chk("m_fault", {31'd0, fault}, {31'd0, m_mode == 3});
         chk("m_count", {16'd0, fetch_count}, m_cnt);
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1; run = 0; halt = 0; redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
      cyc(2);
      chk("rst_state", {30'd0, state}, 0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'd0, instr_valid}, 0);
      chk("rst_count", {16'd0, fetch_count}, 0);
      rst = 0;

      // Sequential fetch with decode always ready.
      run = 1; instr_ready = 1;
      cyc();
      chk("go_state", {30'd0, state}, 1);
      chk("go_valid", {31'd0, instr_valid}, 0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("seq_instr", instr, 32'hA000_0000 + k);
         chk("seq_ipc", instr_pc, 4 * k);
      end

      // Stall with word 2 (pc 8) held.
      instr_ready = 0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("stall_instr", instr, 32'hA000_0002);
         chk("stall_ipc", instr_pc, 32'd8);
         chk("stall_addr", imem_addr, 32'd12);
      end
      instr_ready = 1;
      cyc();
      chk("unstall_instr", instr, 32'hA000_0003);
      chk("unstall_ipc", instr_pc, 32'd12);
      cyc();
      chk("count4", {16'd0, fetch_count}, 4);

      // Redirect with misaligned target; the held word is still taken.
      redirect_valid = 1; redirect_pc = 32'h0000_0043;
      cyc();
      redirect_valid = 0;
      chk("redir_valid", {31'd0, instr_valid}, 0);
      chk("redir_addr", imem_addr, 32'h40);
      chk("redir_count", {16'd0, fetch_count}, 5);
      cyc();
      chk("redir_ipc", instr_pc, 32'h40);
      chk("redir_instr", instr, 32'hA000_0010);

      // Halt together with redirect to 0x10, then sit halted.
      run = 0; halt = 1; redirect_valid = 1; redirect_pc = 32'h10;
      cyc();
      halt = 0; redirect_valid = 0;
      chk("halt_state", {30'd0, state}, 2);
      chk("halt_addr", imem_addr, 32'h10);
      cyc(2);
      chk("halted_addr", imem_addr, 32'h10);
      run = 1; halt = 1;
      cyc();
      chk("both_state", {30'd0, state}, 2);
      halt = 0;
      cyc(2);
      chk("resume_ipc", instr_pc, 32'h10);
      chk("resume_instr", instr, 32'hA000_0004);

      // Halt alone with a valid word stuck at decode; it stays transferable.
      instr_ready = 0; halt = 1;
      cyc();
      halt = 0; run = 0;
      chk("halt2_state", {30'd0, state}, 2);
      chk("halt2_valid", {31'd0, instr_valid}, 1);
      instr_ready = 1;
      cyc();
      chk("halt2_drain", {31'd0, instr_valid}, 0);

      // Reset in the middle of traffic.
      run = 1;
      cyc(3);
      rst = 1;
      cyc();
      rst = 0; run = 0;
      chk("mrst_state", {30'd0, state}, 0);
      chk("mrst_valid", {31'd0, instr_valid}, 0);
      chk("mrst_count", {16'd0, fetch_count}, 0);
      chk("mrst_addr", imem_addr, 32'h0);

      // Run to the end of memory: last two words, then the boundary.
      run = 1;
      cyc();
      redirect_valid = 1; redirect_pc = (MW - 2) * 4;
      cyc();
      redirect_valid = 0;
      cyc(2);
      chk("edge_ipc", instr_pc, (MW - 1) * 4);
      cyc();
      if (BCHK) begin
         chk("oob_state", {30'd0, state}, 3);
         chk("oob_fault", {31'd0, fault}, 1);
         chk("oob_addr", imem_addr, MW * 4);
         redirect_valid = 1; redirect_pc = 32'h0;
         cyc();
         redirect_valid = 0;
         chk("oob_sticky", {30'd0, state}, 3);
         chk("oob_hold", imem_addr, MW * 4);
      end else begin
         chk("nochk_state", {30'd0, state}, 1);
         chk("nochk_fault", {31'd0, fault}, 0);
         chk("nochk_ipc", instr_pc, MW * 4);
      end
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_sequencer.md
IF_SEQUENCER -- requirements
Module: if_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter MEM_WORDS, default 100: instruction memory depth in 32-bit words.
REQ-003 SHALL have the following ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  start/resume fetching.
- halt  in  1  stop fetching.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  32  redirect target.
- imem_addr  out  32  byte address to instruction memory.
- imem_rdata  in  32  combinational read data for imem_addr.
- instr_valid  out  1  instruction register holds a valid word.
- instr_ready  in  1  decode accepts the instruction.
- instr  out  32  fetched instruction.
- instr_pc  out  32  byte address of instr.
- state  out  2  FSM state: 0 IDLE, 1 FETCH, 2 HALTED, 3 FAULT.
- fault  out  1  out-of-range fetch detected.
- fetch_count  out  16  instructions handed to decode.

Function
REQ-004 SHALL hold an internal pc register; imem_addr SHALL equal pc combinationally in every state.
REQ-005 SHALL keep pc word-aligned: pc[1:0] always 2'b00; redirect_pc[1:0] ignored.
REQ-006 IDLE: no fetch, instr_valid held 0; run=1 -> FETCH at next edge.
REQ-007 FETCH: load condition = (!instr_valid || instr_ready); on load, instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (mod 2^32).
REQ-008 FETCH with instr_valid=1 and instr_ready=0: instr, instr_pc, pc, instr_valid all held (stall).
REQ-009 Instruction latency: imem word at pc appears on instr exactly one cycle after the load edge.
REQ-010 A transfer SHALL occur on each edge where instr_valid=1 and instr_ready=1; fetch_count SHALL increment by 1 per transfer, saturating at 16'hFFFF.
REQ-011 redirect_valid=1 in FETCH or HALTED: pc<={redirect_pc[31:2],2'b00}, instr_valid<=0 at next edge (flush); redirect overrides any load that cycle. A transfer on that same edge still counts.
REQ-012 redirect_valid ignored in IDLE and FAULT.
REQ-013 halt=1 in FETCH: -> HALTED at next edge; no load that cycle; instr_valid held, existing instruction still transferable.
REQ-014 HALTED: no load; run=1 and halt=0 -> FETCH resuming from current pc; halt and run both 1 -> stay HALTED.
REQ-015 Simultaneous halt and redirect in FETCH: both apply (pc redirected, flush, -> HALTED).
REQ-016 halt in IDLE: stay IDLE.
REQ-017 fault SHALL be 1 iff state = FAULT.

Reset
REQ-018 rst=1 at an edge SHALL force, regardless of state or pending handshake: state IDLE, pc RESET_PC, instr_valid 0, instr 0, instr_pc 0, fault 0, fetch_count 0.
REQ-019 rst SHALL take priority over run, halt, redirect_valid and instr_ready.

Configuration
REQ-020 Macro IF_BOUNDS_CHECK_EN defined: in FETCH, if (pc>>2) >= MEM_WORDS and a load would occur, no load, pc held, -> FAULT; FAULT exits only via rst; held instruction remains transferable.
REQ-021 Macro IF_BOUNDS_CHECK_EN undefined: no range check, FAULT unreachable, fault constant 0.

Verification
REQ-022 rst then run=1, instr_ready=1, memory words 0..3 = A0,A1,A2,A3 -> instr A0..A3 on consecutive cycles, instr_pc 0,4,8,12, fetch_count 4.
REQ-023 instr_ready=0 for 3 cycles while instr_valid=1 at pc 8 -> instr, instr_pc=8, imem_addr=12 stable; ready=1 -> next word from 12, no skip or duplicate.
REQ-024 redirect_valid=1, redirect_pc=32'h0000_0043 during FETCH -> next cycle instr_valid=0, imem_addr=0x40; following cycle instr_pc=0x40.
REQ-025 halt=1 at pc 0x10 -> HALTED, imem_addr held 0x10; run=1 -> fetch resumes at 0x10; rst mid-stream -> state 0, instr_valid 0, fetch_count 0, imem_addr RESET_PC.
REQ-026 With IF_BOUNDS_CHECK_EN, MEM_WORDS=4, ready=1 -> 4 transfers, then state 3, fault=1, imem_addr=16; without macro -> fetch continues to address 16, fault=0.
